// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
//
// Contents:
//   arb_state_e  arbiter state: IDLE (round-robin) or LOCKED (burst owner held)
//   STAT_W       width of the optional statistics counters
//   MAX_REQ      largest supported requester count
//   pick_t       result of a round-robin search {found, idx}
//   rr_pick      round-robin priority search over up to MAX_REQ requests
package bram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Searches req starting at ptr and wrapping modulo MAX_REQ. Callers pad
  // unused request bits with zeros and keep ptr below their requester
  // count, so the modulo-8 wrap visits exactly the same order as a
  // modulo-NUM_REQ wrap would.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0] ptr);
    pick_t      res;
    logic [2:0] idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + 3'(k);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_rr_picker.sv
// Combinational round-robin priority search.
//
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   IDW      highest-priority index this cycle
//   found  out  1        at least one request is asserted
//   idx    out  IDW      first asserted request at or after ptr (with wrap)
module bram_rr_picker
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  logic [MAX_REQ-1:0] req_pad;
  pick_t              pick;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
    pick                 = rr_pick(req_pad, 3'(ptr));
  end

  assign found = pick.found;
  assign idx   = IDW'(pick.idx);

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port between NUM_REQ requesters with round-robin
// arbitration and an optional burst lock. One beat (read or write) per
// cycle; read data returns tagged with the requester ID one cycle later.
//
// Handshake: a beat from requester i is accepted in the cycle where
// req_valid[i] && req_ready[i]. req_ready is one-hot (or zero), is only
// raised for a requester whose req_valid is high, and never depends on
// anything but the current state and req_valid. Responses carry no
// backpressure: rsp_valid is a single-cycle strobe.
//
// Optional feature (define BRAM_ARB_STATS_EN): adds grant_cnt (per-requester
// saturating accepted-beat counters, 16 bits each) and stall_cnt (saturating
// count of cycles with some request pending and nothing accepted).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/we/lock per-requester request, write flag, burst lock
//   req_addr/wdata   packed per-requester address and write data
//   req_ready        one-hot accept
//   rsp_valid/id/data read response (data passes straight from the RAM)
//   bram_*           RAM port controls; addr/data hold when idle
//   grant_cnt, stall_cnt  statistics (BRAM_ARB_STATS_EN only)
//   dbg_state        current arbiter state (0 = IDLE, 1 = LOCKED)
//   dbg_rr_ptr       current round-robin pointer
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 1024,
  parameter int NUM_REQ = 4,
  localparam int AW  = $clog2(DEPTH),
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     bram_read_en,
  output logic                     bram_write_en,
  output logic [AW-1:0]            bram_addr,
  output logic [WIDTH-1:0]         bram_data_in,
  input  logic [WIDTH-1:0]         bram_data_out,
`ifdef BRAM_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]         stall_cnt,
`endif
  output logic                     dbg_state,
  output logic [IDW-1:0]           dbg_rr_ptr
);

  arb_state_e       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   lock_owner;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             accept;
  logic [IDW-1:0]   grant_idx;
  logic             beat_we;
  logic             beat_lock;
  logic [AW-1:0]    beat_addr;
  logic [WIDTH-1:0] beat_wdata;
  logic [IDW-1:0]   next_ptr;

  bram_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While locked only the owner may be granted; if it is not requesting
  // the port idles and everyone else waits.
  always_comb begin
    accept    = 1'b0;
    grant_idx = pick_idx;
    if (state == LOCKED) begin
      accept    = req_valid[lock_owner];
      grant_idx = lock_owner;
    end else begin
      accept    = pick_found;
    end
    if (rst) accept = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign beat_we    = req_we[grant_idx];
  assign beat_lock  = req_lock[grant_idx];
  assign beat_addr  = req_addr[grant_idx*AW +: AW];
  assign beat_wdata = req_wdata[grant_idx*WIDTH +: WIDTH];
  assign next_ptr   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Write and read take effect at the RAM in the accept cycle; the last
  // address/data are held so the RAM port stays quiet between beats.
  assign bram_write_en = accept & beat_we;
  assign bram_read_en  = accept & ~beat_we;
  assign bram_addr     = accept ? beat_addr  : addr_q;
  assign bram_data_in  = accept ? beat_wdata : wdata_q;

  // The RAM registers its output and holds it while read_en is low.
  assign rsp_data = bram_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_owner <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rsp_valid <= accept & ~beat_we;
      if (accept & ~beat_we) rsp_id <= grant_idx;
      if (accept) begin
        addr_q  <= beat_addr;
        wdata_q <= beat_wdata;
        if (beat_lock) begin
          state      <= LOCKED;
          lock_owner <= grant_idx;
        end else begin
          // Closing a burst or a plain beat: priority moves past the winner.
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end
      end
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

`ifdef BRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_idx == IDW'(i) &&
            grant_cnt[i*STAT_W +: STAT_W] != '1)
          grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + 1'b1;
      end
      if (|req_valid && !accept && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: stimulus tables, hand-written corner
// sequences and a randomized phase, all checked against a round-robin /
// burst-lock reference model. A simple registered RAM sits on the port.
module tb_bram_port_arbiter;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 1024;
  localparam int NUM_REQ = 4;
  localparam int AW      = 10;
  localparam int IDW     = 2;
  localparam int SAT     = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_we    = '0;
  logic [NUM_REQ-1:0]       req_lock  = '0;
  logic [NUM_REQ*AW-1:0]    req_addr  = '0;
  logic [NUM_REQ*WIDTH-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     bram_read_en;
  logic                     bram_write_en;
  logic [AW-1:0]            bram_addr;
  logic [WIDTH-1:0]         bram_data_in;
  logic [WIDTH-1:0]         bram_data_out;
  logic                     dbg_state;
  logic [IDW-1:0]           dbg_rr_ptr;
`ifdef BRAM_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]    grant_cnt;
  logic [15:0]              stall_cnt;
`endif

  bram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .bram_read_en  (bram_read_en),
    .bram_write_en (bram_write_en),
    .bram_addr     (bram_addr),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out),
`ifdef BRAM_ARB_STATS_EN
    .grant_cnt     (grant_cnt),
    .stall_cnt     (stall_cnt),
`endif
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr)
  );

  // Registered-output RAM on the arbitrated port.
  logic [WIDTH-1:0] bram_mem[DEPTH];
  always @(posedge clk) begin
    if (bram_write_en) bram_mem[bram_addr] <= bram_data_in;
    if (bram_read_en)  bram_data_out <= bram_mem[bram_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0]     ref_mem[DEPTH];
  logic [IDW+WIDTH-1:0] exp_q[$];
  int                   ptr_m;
  int                   owner_m;   // -1 when no burst is open
  bit                   pend_m;
  bit                   have_last;
  logic [AW-1:0]        last_addr;
  logic [WIDTH-1:0]     last_wdata;
  int                   gcnt[NUM_REQ];
  int                   scnt;

  logic [AW-1:0]      a[NUM_REQ];
  logic [WIDTH-1:0]   d[NUM_REQ];
  logic [NUM_REQ-1:0] seen_ready;
  logic               seen_state;
  int                 seen_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0; owner_m = -1; pend_m = 0; have_last = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
    scnt = 0;
  endtask

  // Who the specification says wins this cycle.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    if (owner_m >= 0) return v[owner_m] ? owner_m : -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr_m + k) % NUM_REQ]) return (ptr_m + k) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] we,
                      input logic [NUM_REQ-1:0] lk);
    int g;
    logic [NUM_REQ-1:0]   er;
    logic [IDW+WIDTH-1:0] e;
    req_valid = v; req_we = we; req_lock = lk;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*AW +: AW]       = a[i];
      req_wdata[i*WIDTH +: WIDTH] = d[i];
    end
    #1;
    seen_ready = req_ready; seen_state = dbg_state; seen_ptr = int'(dbg_rr_ptr);
    g  = model_pick(v);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("bram_write_en", 32'(bram_write_en), (g >= 0) ? 32'(we[g]) : 32'd0);
    chk("bram_read_en", 32'(bram_read_en), (g >= 0) ? 32'(!we[g]) : 32'd0);
    if (g >= 0) begin
      chk("bram_addr", 32'(bram_addr), 32'(a[g]));
      chk("bram_data_in", 32'(bram_data_in), 32'(d[g]));
    end else if (have_last) begin
      chk("bram_addr_hold", 32'(bram_addr), 32'(last_addr));
      chk("bram_data_hold", 32'(bram_data_in), 32'(last_wdata));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(pend_m));
    if (pend_m && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e[IDW+WIDTH-1:WIDTH]));
      chk("rsp_data", 32'(rsp_data), 32'(e[WIDTH-1:0]));
    end
    chk("state", 32'(dbg_state), 32'(owner_m >= 0));
    chk("rr_ptr", 32'(dbg_rr_ptr), 32'(ptr_m));
`ifdef BRAM_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(gcnt[i]));
    chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
`endif
    @(posedge clk);
    pend_m = 0;
    if (g >= 0) begin
      if (we[g]) ref_mem[a[g]] = d[g];
      else begin
        pend_m = 1;
        exp_q.push_back({IDW'(g), ref_mem[a[g]]});
      end
      last_addr = a[g]; last_wdata = d[g]; have_last = 1;
      if (lk[g]) owner_m = g;
      else begin
        owner_m = -1;
        ptr_m   = (g + 1) % NUM_REQ;
      end
      if (gcnt[g] < SAT) gcnt[g]++;
    end else if (|v) begin
      if (scnt < SAT) scnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '1; req_we = '0; req_lock = '1;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst read_en", 32'(bram_read_en), 32'd0);
    chk("rst write_en", 32'(bram_write_en), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_id", 32'(rsp_id), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    chk("rst rr_ptr", 32'(dbg_rr_ptr), 32'd0);
`ifdef BRAM_ARB_STATS_EN
    chk("rst grant_cnt", 32'(|grant_cnt), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_lock = '0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               rst_first;
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] we;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_locked;
    int                 exp_ptr;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic [NUM_REQ-1:0] rv, rw, rl, prev_v;
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = 16'(i * 37 + 1);
      ref_mem[i]  = 16'(i * 37 + 1);
    end
    bram_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin a[i] = '0; d[i] = '0; end
    model_reset();

    // fairness: everyone reads continuously
    vecs.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h1, 1'b0, 0});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 1'b0, 1});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 1'b0, 2});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h8, 1'b0, 3});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 1'b0, 0});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 1'b0, 1});
    // burst lock: req0 writes 3 locked + 1 unlocked while req3 waits
    vecs.push_back('{1'b1, 4'h9, 4'h1, 4'h1, 4'h1, 1'b0, 0});
    vecs.push_back('{1'b0, 4'h9, 4'h1, 4'h1, 4'h1, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h9, 4'h1, 4'h1, 4'h1, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h9, 4'h1, 4'h0, 4'h1, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h8, 4'h0, 4'h0, 4'h8, 1'b0, 1});
    // lock bubble: owner drops valid for two cycles, req2 must wait
    vecs.push_back('{1'b1, 4'h5, 4'h0, 4'h1, 4'h1, 1'b0, 0});
    vecs.push_back('{1'b0, 4'h4, 4'h0, 4'h1, 4'h0, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h4, 4'h0, 4'h1, 4'h0, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h5, 4'h0, 4'h0, 4'h1, 1'b1, 0});
    vecs.push_back('{1'b0, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 1});

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rst_first) do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
        a[i] = AW'(16 * i + n);
        d[i] = WIDTH'($urandom);
      end
      step(vecs[n].valid, vecs[n].we, vecs[n].lock);
      chk("vec ready", 32'(seen_ready), 32'(vecs[n].exp_ready));
      chk("vec locked", 32'(seen_state), 32'(vecs[n].exp_locked));
      chk("vec rr_ptr", 32'(seen_ptr), 32'(vecs[n].exp_ptr));
    end

    // write then read the same address from another requester
    a[1] = 10'd5; d[1] = 16'hBEEF;
    step(4'b0010, 4'b0010, 4'b0000);
    a[2] = 10'd5;
    step(4'b0100, 4'b0000, 4'b0000);
    chk("wr_rd rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rd rsp_id", 32'(rsp_id), 32'd2);
    chk("wr_rd rsp_data", 32'(rsp_data), 32'hBEEF);
    step(4'b0000, 4'b0000, 4'b0000);

    // reset during a locked burst with a read in flight
    do_reset();
    a[0] = 10'd7;
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001);
    chk("midburst rsp_valid", 32'(rsp_valid), 32'd1);
    chk("midburst locked", 32'(dbg_state), 32'd1);
    do_reset();
    step(4'b0110, 4'b0000, 4'b0000);
    chk("first grant after reset", 32'(seen_ready), 32'b0010);

    // randomized traffic, small address range for read-after-write hits
    do_reset();
    prev_v = '0; rw = '0;
    for (int n = 0; n < 600; n++) begin
      rv = NUM_REQ'($urandom);
      rl = NUM_REQ'($urandom) & NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        // a pending beat keeps its command until it is accepted
        if (!prev_v[i] || seen_ready[i]) begin
          a[i]  = AW'($urandom_range(0, 15));
          d[i]  = WIDTH'($urandom);
          rw[i] = 1'($urandom_range(0, 1));
        end
      end
      step(rv, rw, rl);
      prev_v = rv;
    end
    step(4'b0000, 4'b0000, 4'b0000);

`ifdef BRAM_ARB_STATS_EN
    // saturate requester 0's counter
    do_reset();
    a[0] = 10'd3;
    for (int n = 0; n < 70000; n++) step(4'b0001, 4'b0000, 4'b0000);
    chk("grant_cnt sat", 32'(grant_cnt[15:0]), 32'hFFFF);
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0000);
    chk("grant_cnt hold", 32'(grant_cnt[15:0]), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the true-dual-port block RAM between NUM_REQ requesters, using round-robin arbitration with an optional burst lock.
- Issues one read or write per cycle to the RAM port.
- Returns read data tagged with the requester ID after the RAM's fixed 1-cycle read latency.
- One instance is placed in front of each RAM port that has more than one client.

Parameters:
- WIDTH, 16, RAM data width.
- DEPTH, 1024, RAM depth; AW = $clog2(DEPTH).
- NUM_REQ, 4, number of requesters (2..8); IDW = $clog2(NUM_REQ).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep the grant for the next beat (burst).
- req_addr  in  NUM_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot; the access is accepted this cycle.
- rsp_valid  out  1  read data valid.
- rsp_id  out  IDW  requester that owns rsp_data.
- rsp_data  out  WIDTH  read data.
- bram_read_en  out  1  RAM read enable.
- bram_write_en  out  1  RAM write enable.
- bram_addr  out  AW  RAM address.
- bram_data_in  out  WIDTH  RAM write data.
- bram_data_out  in  WIDTH  RAM read data, registered inside the RAM.

Behaviour:
- Reset values:
  - rr_ptr = 0, state = IDLE, rsp_valid = 0, rsp_id = 0.
  - req_ready = 0 and bram_read_en = bram_write_en = 0 while rst is high.
- Grant selection (combinational):
  - In IDLE, grant the first asserted req_valid, searching from rr_ptr upward with wrap.
  - In LOCKED, only lock_owner may be granted.
- An accepted beat is req_valid[g] & req_ready[g]. On that cycle:
  - drive bram_addr and bram_data_in from requester g;
  - bram_write_en = req_we[g];
  - bram_read_en = ~req_we[g].
- When no beat is accepted, both RAM enables are 0 and addr/data hold their last values.
- rr_ptr update: after an accepted beat without req_lock[g], rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- State machine:
  - IDLE -> LOCKED when the accepted beat has req_lock[g] = 1; lock_owner <= g.
  - LOCKED stays while the owner's accepted beats keep req_lock = 1.
  - LOCKED -> IDLE on an accepted owner beat with req_lock = 0; rr_ptr then advances past the owner.
  - In LOCKED with owner req_valid = 0: no grant (idle bubble), stay LOCKED. Other requesters stall.
- Read response:
  - rsp_valid is registered: it is high exactly 1 cycle after an accepted read.
  - rsp_id is the registered g.
  - rsp_data = bram_data_out (pass-through; the RAM holds it while read_en is low).
  - There is no response backpressure; requesters must always accept.
- Throughput and latency: one beat per cycle sustained, back-to-back across requesters. Write accept-to-RAM = 0 cycles; read accept-to-rsp = 1 cycle.
- Write-then-read to the same address in consecutive cycles returns the new data. A same-cycle read and write on one port cannot occur.
- A write on the other RAM port to the same address is the system's responsibility; no cross-port check is made.
- Reset mid-burst: the lock is dropped, an in-flight rsp_valid is cleared, and rr_ptr returns to 0.
- req_we/req_addr/req_wdata must be stable while req_valid is high and the beat is not yet accepted.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- When defined, the block adds:
  - grant_cnt output, NUM_REQ*16 bits: per-requester saturating accepted-beat counters;
  - stall_cnt output, 16 bits: saturating count of cycles with any req_valid high and no beat accepted.
- Both counters are cleared by rst and saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package bram_arb_pkg holds:
  - arb_state_e {IDLE, LOCKED};
  - localparam STAT_W = 16;
  - function rr_pick(req, ptr), which returns the grant index and a found flag.
- One sub-module is natural: bram_rr_picker, the combinational round-robin priority search, which is parameterised by NUM_REQ.

Test Plan:
- Fairness: all 4 requesters hold a read continuously from rst release -> grants 0,1,2,3,0,... one per cycle; rsp_id follows the grant order 1 cycle later.
- Write then read: req1 writes 16'hBEEF to addr 5, next cycle req2 reads addr 5 -> rsp_valid with rsp_id = 2, rsp_data = 16'hBEEF one cycle after the read.
- Burst lock: req0 issues 3 locked writes then 1 unlocked write while req3 is pending -> req3 is granted only after the 4th req0 beat; rr_ptr = 1 afterwards.
- Lock bubble: req0 is locked and drops req_valid for 2 cycles -> no RAM enables for 2 cycles, req2 is not granted, state stays LOCKED.
- Reset mid-burst: assert rst during LOCKED with a read in flight -> rsp_valid = 0 immediately, state IDLE, first grant after release goes to the lowest-indexed valid requester.
- Stats (BRAM_ARB_STATS_EN): drive 70000 req0 beats -> grant_cnt[0] = 16'hFFFF and holds there.
